// File: rtl/storage_arbiter_pkg.sv
// Shared types and helpers for the matrix storage arbiter: channel index
// width and the read-return pipeline entry.
package storage_arbiter_pkg;

  // Widest channel tag the pipeline ever carries (N_CH is at most 8).
  localparam int MAX_CH_W = 3;

  // Channel index width: max(1, clog2(n)).
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                valid;
    logic [MAX_CH_W-1:0] ch;
  } rd_entry_t;

  localparam rd_entry_t RD_IDLE = '{valid: 1'b0, ch: '0};

endpackage

// File: rtl/storage_arbiter_rr_pick.sv
// Combinational rotate-priority picker: the first requester found when
// searching upward from ptr (wrapping modulo N) wins.
module storage_arbiter_rr_pick #(
  parameter int N = 3,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [W-1:0] cand;

  // NOTE: every output of a combinational block gets a default before any
  // branch; a path that leaves one unassigned would infer a latch.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = 0; i < N; i++) begin
      cand = W'((int'(ptr) + i) % N);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/storage_arbiter.sv
// N-channel request/grant arbiter in front of the single-port matrix storage,
// with burst locking and tagged read returns.
module storage_arbiter
  import storage_arbiter_pkg::*;
#(
  parameter int N_CH   = 3,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1,
  parameter int RR_EN  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          i_req,
  input  logic [N_CH-1:0]          i_we,
  input  logic [N_CH-1:0]          i_lock,
  input  logic [N_CH*ADDR_W-1:0]   i_addr,
  input  logic [N_CH*DATA_W-1:0]   i_wdata,
  output logic [N_CH-1:0]          o_gnt,
  output logic [N_CH-1:0]          o_rvalid,
  output logic [DATA_W-1:0]        o_rdata,
  output logic                     o_mem_we,
  output logic [ADDR_W-1:0]        o_mem_addr,
  output logic [DATA_W-1:0]        o_mem_wdata,
  input  logic [DATA_W-1:0]        i_mem_rdata,
  output logic                     o_busy
);

  localparam int CH_W = ch_w(N_CH);

  logic [CH_W-1:0] ptr_q, ptr_d;
  logic            lock_vld_q, lock_vld_d;
  logic [CH_W-1:0] lock_ch_q, lock_ch_d;
  rd_entry_t       rd_pipe_q [RD_LAT];
  rd_entry_t       rd_push;
  rd_entry_t       rd_tail;
  logic            rd_inflight;

  logic            lock_hit;
  logic [CH_W-1:0] pick_ptr;
  logic [N_CH-1:0] pick_gnt;
  logic [CH_W-1:0] pick_idx;
  logic            pick_any;
  logic [N_CH-1:0] gnt;
  logic [CH_W-1:0] gnt_idx;
  logic            gnt_any;

  function automatic logic [CH_W-1:0] ch_inc(input logic [CH_W-1:0] c);
    return (int'(c) == N_CH - 1) ? '0 : c + CH_W'(1);
  endfunction

  // The lock only binds while its owner keeps requesting.
  assign lock_hit = lock_vld_q && i_req[lock_ch_q];
  assign pick_ptr = (RR_EN != 0) ? ptr_q : '0;

  storage_arbiter_rr_pick #(
    .N (N_CH),
    .W (CH_W)
  ) u_pick (
    .req (i_req),
    .ptr (pick_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Requests seen while rst is high never reach the storage.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    if (!rst) begin
      if (lock_hit) begin
        gnt[lock_ch_q] = 1'b1;
        gnt_idx        = lock_ch_q;
        gnt_any        = 1'b1;
      end else begin
        gnt     = pick_gnt;
        gnt_idx = pick_idx;
        gnt_any = pick_any;
      end
    end
  end

  // A release (owner drops i_req or stops locking) moves ptr to owner+1,
  // even if another channel is granted in the same cycle.
  always_comb begin
    ptr_d      = ptr_q;
    lock_vld_d = lock_vld_q;
    lock_ch_d  = lock_ch_q;
    if (lock_hit) begin
      if (!i_lock[lock_ch_q]) begin
        lock_vld_d = 1'b0;
        ptr_d      = ch_inc(lock_ch_q);
      end
    end else begin
      if (lock_vld_q) begin
        lock_vld_d = 1'b0;
        ptr_d      = ch_inc(lock_ch_q);
      end
      if (gnt_any) begin
        if (i_lock[gnt_idx]) begin
          lock_vld_d = 1'b1;
          lock_ch_d  = gnt_idx;
        end else if (!lock_vld_q) begin
          ptr_d = ch_inc(gnt_idx);
        end
      end
    end
  end

  always_comb begin
    rd_push = RD_IDLE;
    if (gnt_any && !i_we[gnt_idx]) begin
      rd_push.valid = 1'b1;
      rd_push.ch    = MAX_CH_W'(gnt_idx);
    end
  end

  // NOTE: registers use non-blocking assignment so every flop samples the
  // pre-edge value; blocking here would collapse the read pipeline into one stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      lock_vld_q <= 1'b0;
      lock_ch_q  <= '0;
      // NOTE: the pipeline holds only tags, so it is cheap to reset, and it
      // must be: a stale valid bit would raise o_rvalid for a dropped read.
      for (int i = 0; i < RD_LAT; i++) rd_pipe_q[i] <= RD_IDLE;
    end else begin
      ptr_q      <= ptr_d;
      lock_vld_q <= lock_vld_d;
      lock_ch_q  <= lock_ch_d;
      rd_pipe_q[0] <= rd_push;
      for (int i = 1; i < RD_LAT; i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
    end
  end

  assign rd_tail = rd_pipe_q[RD_LAT-1];

  always_comb begin
    rd_inflight = 1'b0;
    for (int i = 0; i < RD_LAT; i++) rd_inflight = rd_inflight | rd_pipe_q[i].valid;
  end

  always_comb begin
    o_rvalid = '0;
    for (int k = 0; k < N_CH; k++) begin
      o_rvalid[k] = !rst && rd_tail.valid && (int'(rd_tail.ch) == k);
    end
  end

  always_comb begin
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (gnt[k]) begin
        o_mem_we    = i_we[k];
        o_mem_addr  = i_addr[k*ADDR_W +: ADDR_W];
        o_mem_wdata = i_wdata[k*DATA_W +: DATA_W];
      end
    end
  end

  assign o_gnt   = gnt;
  assign o_rdata = i_mem_rdata;
  assign o_busy  = !rst && (lock_vld_q || rd_inflight);

endmodule

// File: tb/tb_storage_arbiter.sv
// Randomised and directed bench for storage_arbiter in two configurations
// (round-robin/RD_LAT=1 and fixed-priority/RD_LAT=3) against a rule-level model.
module tb_storage_arbiter;

  localparam int N  = 3;
  localparam int AW = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  typedef struct {
    int            ch;
    logic [DW-1:0] data;
    int            due;
  } rd_exp_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input int a);
    return (32'(a) * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [N*AW-1:0] pa(input int a0, input int a1, input int a2);
    return {AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  function automatic logic [N*DW-1:0] pd(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                          input logic [DW-1:0] d2);
    return {d2, d1, d0};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int CFG = g;
    localparam int RR  = (g == 0) ? 1 : 0;
    localparam int LAT = (g == 0) ? 1 : 3;

    logic            rst;
    logic [N-1:0]    req, we, lk, gnt, rvalid;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [DW-1:0]   rdata, mem_rdata, mem_wdata;
    logic            mem_we, busy;
    logic [AW-1:0]   mem_addr;

    storage_arbiter #(
      .N_CH(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .RR_EN(RR)
    ) dut (
      .clk(clk), .rst(rst), .i_req(req), .i_we(we), .i_lock(lk),
      .i_addr(addr), .i_wdata(wdata), .o_gnt(gnt), .o_rvalid(rvalid),
      .o_rdata(rdata), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
      .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .o_busy(busy)
    );

    // Storage environment: writes land at the grant edge, reads return LAT cycles later.
    logic [DW-1:0] mem [256];
    bit            written [256];
    logic [DW-1:0] rd_sh [LAT];
    always @(posedge clk) begin
      if (mem_we) begin
        mem[mem_addr]     <= mem_wdata;
        written[mem_addr] <= 1'b1;
      end
      rd_sh[0] <= written[mem_addr] ? mem[mem_addr] : init_val(int'(mem_addr));
      for (int i = 1; i < LAT; i++) rd_sh[i] <= rd_sh[i-1];
    end
    assign mem_rdata = rd_sh[LAT-1];

    // Reference model state: pointer, lock owner (-1 = none), storage contents.
    int            m_ptr = 0;
    int            m_owner = -1;
    rd_exp_t       exp_q[$];
    logic [DW-1:0] ref_mem [int];

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(int'(a));
    endfunction

    function automatic int pick(input logic [N-1:0] rq);
      if (m_owner >= 0 && rq[m_owner]) return m_owner;
      for (int i = 0; i < N; i++) begin
        int k = (RR != 0) ? (m_ptr + i) % N : i;
        if (rq[k]) return k;
      end
      return -1;
    endfunction

    task automatic update(input logic [N-1:0] rq, input logic [N-1:0] lv, input int gi);
      if (m_owner >= 0 && rq[m_owner]) begin
        if (!lv[gi]) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
        end
      end else begin
        bit released = (m_owner >= 0);
        if (released) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
        end
        if (gi >= 0) begin
          if (lv[gi]) m_owner = gi;
          else if (!released) m_ptr = (gi + 1) % N;
        end
      end
    endtask

    task automatic step(input bit r, input logic [N-1:0] rq, input logic [N-1:0] wv,
                        input logic [N-1:0] lv, input logic [N*AW-1:0] a,
                        input logic [N*DW-1:0] d, output int gi);
      logic [N-1:0]  gnt_exp;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      logic          ew;
      bit            busy_exp;
      @(negedge clk);
      rst = r; req = rq; we = wv; lk = lv; addr = a; wdata = d;
      #1;
      busy_exp = !r && (m_owner >= 0 || exp_q.size() > 0);
      gi = r ? -1 : pick(rq);
      gnt_exp = '0; ea = '0; ed = '0; ew = 1'b0;
      if (gi >= 0) begin
        gnt_exp[gi] = 1'b1;
        ea = a[gi*AW +: AW];
        ed = d[gi*DW +: DW];
        ew = wv[gi];
      end
      check($sformatf("cfg%0d gnt", CFG), gnt, gnt_exp);
      check($sformatf("cfg%0d mem_we", CFG), mem_we, ew);
      check($sformatf("cfg%0d mem_addr", CFG), mem_addr, ea);
      check($sformatf("cfg%0d mem_wdata", CFG), mem_wdata, ed);
      check($sformatf("cfg%0d busy", CFG), busy, busy_exp);
      if (r) begin
        m_ptr = 0;
        m_owner = -1;
        exp_q.delete();
      end else begin
        if (gi >= 0) begin
          if (ew) ref_mem[int'(ea)] = ed;
          else exp_q.push_back('{ch: gi, data: ref_rd(ea), due: cyc + LAT});
        end
        update(rq, lv, gi);
      end
    endtask

    // Monitor: pops the scoreboard whenever a read strobe appears or one is overdue.
    always @(negedge clk) begin
      rd_exp_t      e;
      logic [N-1:0] oh;
      #2;
      if (rvalid != '0) begin
        if (exp_q.size() == 0) begin
          check($sformatf("cfg%0d unexpected_rvalid", CFG), rvalid, '0);
        end else begin
          e = exp_q.pop_front();
          oh = '0;
          oh[e.ch] = 1'b1;
          check($sformatf("cfg%0d rvalid", CFG), rvalid, oh);
          check($sformatf("cfg%0d rdata", CFG), rdata, e.data);
          check($sformatf("cfg%0d rd_cycle", CFG), cyc, e.due);
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        oh = '0;
        oh[e.ch] = 1'b1;
        check($sformatf("cfg%0d rvalid_missing", CFG), rvalid, oh);
      end
    end

    initial begin
      int           gi;
      logic [N-1:0] pend, s_we, s_lk;
      logic [N*AW-1:0] s_addr;
      logic [N*DW-1:0] s_wdata;
      bit           r;
      rst = 1'b1; req = '0; we = '0; lk = '0; addr = '0; wdata = '0;

      // Reset, with requests present that must not be granted.
      step(1, '1, '0, '0, pa(1, 2, 3), '0, gi);
      step(1, '0, '0, '0, '0, '0, gi);
      // Everyone reads continuously.
      repeat (4) step(0, 3'b111, 3'b000, 3'b000, pa('h10, 'h20, 'h30), '0, gi);
      step(0, '0, '0, '0, '0, '0, gi);
      // ch1 locked 4-write burst with ch0 waiting, then release.
      step(0, 3'b010, 3'b010, 3'b010, pa(0, 'h40, 0), pd(0, 32'h1111_0040, 0), gi);
      for (int j = 1; j < 4; j++)
        step(0, 3'b011, 3'b010, 3'b010, pa('h50, 'h40 + j, 0), pd(0, 32'h1111_0040 + j, 0), gi);
      step(0, 3'b001, 3'b000, 3'b000, pa('h50, 0, 0), '0, gi);
      step(0, 3'b111, 3'b000, 3'b000, pa('h41, 'h42, 'h43), '0, gi);
      // Write then read of the same address.
      step(0, 3'b001, 3'b001, 3'b000, pa(5, 0, 0), pd(32'hDEAD_BEEF, 0, 0), gi);
      step(0, 3'b010, 3'b000, 3'b000, pa(0, 5, 0), '0, gi);
      // Interleaved reads and a write.
      step(0, 3'b100, 3'b000, 3'b000, pa(0, 0, 'h30), '0, gi);
      step(0, 3'b001, 3'b000, 3'b000, pa('h10, 0, 0), '0, gi);
      step(0, 3'b010, 3'b010, 3'b000, pa(0, 7, 0), pd(0, 32'h0BAD_F00D, 0), gi);
      step(0, 3'b100, 3'b000, 3'b000, pa(0, 0, 5), '0, gi);
      // Reset one cycle after a locked read grant.
      step(0, 3'b010, 3'b000, 3'b010, pa(0, 'h20, 0), '0, gi);
      step(1, 3'b001, 3'b000, 3'b000, pa('h11, 0, 0), '0, gi);
      step(0, 3'b101, 3'b000, 3'b000, pa('h11, 0, 'h31), '0, gi);
      repeat (4) step(0, '0, '0, '0, '0, '0, gi);

      // Random traffic; pending requesters hold their request until granted.
      pend = '0; s_we = '0; s_addr = '0; s_wdata = '0;
      for (int c = 0; c < 400; c++) begin
        for (int k = 0; k < N; k++) begin
          if (!pend[k] && $urandom_range(0, 99) < 55) begin
            pend[k] = 1'b1;
            s_we[k] = 1'($urandom_range(0, 1));
            s_addr[k*AW +: AW] = AW'($urandom_range(0, 15));
            s_wdata[k*DW +: DW] = $urandom;
          end
        end
        s_lk = N'($urandom) & N'($urandom);
        r = ($urandom_range(0, 149) == 0);
        step(r, pend, s_we, s_lk, s_addr, s_wdata, gi);
        if (gi >= 0) pend[gi] = 1'b0;
      end
      repeat (LAT + 3) step(0, '0, '0, '0, '0, '0, gi);
      check($sformatf("cfg%0d reads_outstanding", CFG), 64'(exp_q.size()), 0);
      done_cnt++;
    end
  end

  initial begin
    repeat (20000) begin
      @(posedge clk);
      if (done_cnt == 2) break;
    end
    check("all_configs_done", 64'(done_cnt), 2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
